sha256_kw_sched: RTL and testbench
==================================

Name: sha256_kw_sched

Overview:
- Downstream consumer of the memory manager's 4-bank RAM once the ROM copy is complete.
- Accepts one 512-bit message block as 16 big-endian 32-bit words.
- Generates the message schedule W[0..63] with a 16-word sliding window.
- Reads round constant K[t] from RAM and streams KW[t] = K[t] + W[t] (mod 2^32) to the compression core over a valid/ready handshake.

Parameters:
- K_BASE, 8: RAM word index of K[0]. H0..H7 occupy words 0..7.
- ADDR_W, 7: RAM word-address width (72 words used).
- RAM_LAT, 1: RAM read latency in cycles, from RAM_RD to RAM_DATA valid.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- COPY_ROM_COMPLETE  in  1  high = RAM holds H/K constants; START is ignored while low.
- START  in  1  one-cycle pulse; begins a block.
- MSG_WORD  in  32  message word, W[0] first.
- MSG_VALID  in  1  MSG_WORD valid.
- MSG_READY  out  1  block accepts a message word.
- RAM_ADDR  out  ADDR_W  word address. Bank_1 supplies bits 31:24 and bank_4 supplies bits 7:0.
- RAM_RD  out  1  read strobe.
- RAM_DATA  in  32  concatenated bank outputs {bank_1, bank_2, bank_3, bank_4}.
- KW  out  32  K[t]+W[t].
- KW_VALID  out  1  KW valid.
- KW_READY  in  1  consumer accepts KW.
- ROUND  out  6  t of the current KW.
- BUSY  out  1  high from accepted START until DONE.
- DONE  out  1  one-cycle pulse after the KW[63] transfer.

Behaviour:
- Reset values: MSG_READY, RAM_RD, KW_VALID, BUSY and DONE are 0. RAM_ADDR, KW and ROUND are 0. The window and counters are cleared.
- RST assertion mid-operation aborts immediately and returns to IDLE. No DONE is produced.
- FSM states: IDLE, LOAD, RD, WAIT, OUT, FIN.
- IDLE: START && COPY_ROM_COMPLETE moves to LOAD and sets BUSY. START while busy, or while COPY_ROM_COMPLETE is low, is ignored.
- LOAD: MSG_READY=1. Each MSG_VALID&&MSG_READY cycle shifts MSG_WORD into window slot 15. After the 16th word, MSG_READY drops the next cycle and the FSM moves to RD with t=0.
- RD: RAM_RD=1 and RAM_ADDR=K_BASE+t for exactly one cycle, then WAIT.
- WAIT: lasts RAM_LAT cycles, then RAM_DATA is captured as K.
- Window update in WAIT:
  - t<16: W[t] = window[t].
  - t>=16: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], mod 2^32.
  - s0 = ROTR7^ROTR18^SHR3.
  - s1 = ROTR17^ROTR19^SHR10.
  - Computed words shift into the window. Window depth stays 16.
- OUT: KW_VALID=1 with ROUND=t.
  - KW and ROUND are held stable while KW_READY is low.
  - On a transfer with t<63: t increments and the FSM goes to RD.
  - On a transfer with t=63: the FSM goes to FIN.
- FIN: DONE=1 for one cycle, BUSY clears, then IDLE.
- Throughput is 3 cycles per round (RAM_LAT=1) when KW_READY is held high.
- COPY_ROM_COMPLETE falling mid-block does not affect the block in progress.
- All additions wrap at 32 bits. t never exceeds 63.

Optional Feature:
- Macro: KWSCHED_PREFETCH_EN.
- Defined:
  - The RAM read for t+1 is issued during OUT of round t. The fetched K is held in a one-entry prefetch register.
  - Sustained throughput is 1 KW per cycle with KW_READY high; the first KW appears 2 cycles after the last message word.
  - No read is issued beyond t=63.
  - A stalled KW_READY holds the prefetch register; no reads are duplicated or lost.
- Undefined: the baseline 3-cycle-per-round FSM above.
- KW values and their order are identical in both builds.

Decomposition:
- Package sha256_pkg:
  - word_t (32-bit).
  - K_BASE_DEF=8, H_WORDS=8, ROUNDS=64, BLOCK_WORDS=16.
  - FSM state enum.
  - Functions s0/s1 as pure functions.
- One sub-module: sha256_w_window. It holds the 16-word shift register and the W[t] next-word logic, with inputs load/shift/t and output w_t.

Test Plan:
- "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), KW_READY=1:
  - KW[0]=0xA3EC9318, KW[1]=0x71374491, KW[15]=0xC19BF18C, KW[16]=0x45FDCD41.
  - DONE after 64 transfers; RAM_ADDR spans 8..71.
- START with COPY_ROM_COMPLETE=0 -> MSG_READY, BUSY and RAM_RD stay 0 for 20 cycles.
- KW_READY held low 5 cycles at t=16 -> KW=0x45FDCD41 and ROUND=16 stable throughout; exactly one RAM read for address 24.
- RST pulse during LOAD after 7 words -> all outputs are at reset values in the same cycle; a new START with 16 words yields KW[0]=0xA3EC9318.
- MSG_VALID gaps (every other cycle) -> same KW sequence as the first scenario. START pulse during OUT is ignored.
- With KWSCHED_PREFETCH_EN defined, KW_READY=1 -> 64 KW in 64 consecutive cycles after the first; values identical to the first scenario.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared types, constants and the SHA-256 schedule sigma functions for the KW scheduler.
package sha256_pkg;

  typedef logic [31:0] word_t;

  localparam int K_BASE_DEF  = 8;
  localparam int H_WORDS     = 8;
  localparam int ROUNDS      = 64;
  localparam int BLOCK_WORDS = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RD,
    ST_WAIT,
    ST_OUT,
    ST_FIN
  } state_e;

  function automatic word_t s0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic word_t s1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_w_window.sv
// 16-word message-schedule window: loads the block, then produces W[t] and slides it in for t>=16.
module sha256_w_window
  import sha256_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  word_t      load_word_i,
  input  logic       shift_i,
  input  logic [5:0] t_i,
  output word_t      w_t_o
);

  word_t win_q [BLOCK_WORDS];
  word_t next_w;
  logic  sched;

  // Once t>=16 the window holds W[t-16..t-1] with the oldest word in slot 0.
  assign sched  = (t_i >= 6'(BLOCK_WORDS));
  assign next_w = s1(win_q[14]) + win_q[9] + s0(win_q[1]) + win_q[0];
  assign w_t_o  = sched ? next_w : win_q[t_i[3:0]];

  // NOTE: the window is a small register file rather than a RAM, so it takes the async reset like any other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BLOCK_WORDS; i++) win_q[i] <= '0;
    end else if (load_i || (shift_i && sched)) begin
      for (int i = 0; i < BLOCK_WORDS - 1; i++) win_q[i] <= win_q[i+1];
      win_q[BLOCK_WORDS-1] <= load_i ? load_word_i : next_w;
    end
  end

endmodule

// File: rtl/sha256_kw_sched.sv
// Streams KW[t] = K[t] + W[t] for one message block, reading K[t] from the constant RAM.
// Define KWSCHED_PREFETCH_EN to overlap the K read of round t+1 with the KW transfer of round t.
module sha256_kw_sched
  import sha256_pkg::*;
#(
  parameter int K_BASE  = K_BASE_DEF,
  parameter int ADDR_W  = 7,
  parameter int RAM_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              COPY_ROM_COMPLETE,
  input  logic              START,
  input  logic [31:0]       MSG_WORD,
  input  logic              MSG_VALID,
  output logic              MSG_READY,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_RD,
  input  logic [31:0]       RAM_DATA,
  output logic [31:0]       KW,
  output logic              KW_VALID,
  input  logic              KW_READY,
  output logic [5:0]        ROUND,
  output logic              BUSY,
  output logic              DONE
);

`ifdef KWSCHED_PREFETCH_EN
  localparam bit PREFETCH = 1'b1;
`else
  localparam bit PREFETCH = 1'b0;
`endif

  state_e             state_q, state_d;
  logic [5:0]         t_q, t_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [RAM_LAT-1:0] rd_pipe_q, rd_pipe_d;
  logic [5:0]         rd_round;
  logic               arrive, kw_fire, win_shift;
  word_t              w_t;

  // The top bit of the read pipe marks the cycle RAM_DATA carries the requested K.
  assign arrive    = rd_pipe_q[RAM_LAT-1];
  assign kw_fire   = KW_VALID && KW_READY;
  assign rd_pipe_d = RAM_LAT'({rd_pipe_q, RAM_RD});
  assign RAM_ADDR  = RAM_RD ? ADDR_W'(K_BASE) + ADDR_W'(rd_round) : '0;
  assign ROUND     = t_q;
  assign BUSY      = (state_q != ST_IDLE);

  // NOTE: every output of this block gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    cnt_d     = cnt_q;
    MSG_READY = 1'b0;
    RAM_RD    = 1'b0;
    rd_round  = t_q;
    DONE      = 1'b0;
    win_shift = 1'b0;
    case (state_q)
      ST_IDLE: if (START && COPY_ROM_COMPLETE) begin
        state_d = ST_LOAD;
        t_d     = '0;
        cnt_d   = '0;
      end
      ST_LOAD: begin
        MSG_READY = 1'b1;
        if (MSG_VALID) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'(BLOCK_WORDS - 1)) state_d = ST_RD;
        end
      end
      ST_RD: begin
        RAM_RD  = 1'b1;
        state_d = PREFETCH ? ST_OUT : ST_WAIT;
      end
      ST_WAIT: if (arrive) begin
        win_shift = 1'b1;
        state_d   = ST_OUT;
      end
      ST_OUT: if (kw_fire) begin
        win_shift = PREFETCH;
        if (t_q == 6'(ROUNDS - 1)) begin
          state_d = ST_FIN;
        end else begin
          t_d = t_q + 6'd1;
          if (PREFETCH) begin
            RAM_RD   = 1'b1;
            rd_round = t_q + 6'd1;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_FIN: begin
        DONE    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      t_q       <= '0;
      cnt_q     <= '0;
      rd_pipe_q <= '0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      cnt_q     <= cnt_d;
      rd_pipe_q <= rd_pipe_d;
    end
  end

  sha256_w_window u_window (
    .clk         (CLK),
    .rst         (RST),
    .load_i      (MSG_VALID && MSG_READY),
    .load_word_i (MSG_WORD),
    .shift_i     (win_shift),
    .t_i         (t_q),
    .w_t_o       (w_t)
  );

`ifdef KWSCHED_PREFETCH_EN
  word_t pf_q;
  logic  pf_vld_q;
  word_t k_cur;

  // K for the presented round is either arriving now or parked in the prefetch register after a stall.
  assign k_cur    = pf_vld_q ? pf_q : RAM_DATA;
  assign KW_VALID = (state_q == ST_OUT) && (pf_vld_q || arrive);
  assign KW       = KW_VALID ? k_cur + w_t : '0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pf_q     <= '0;
      pf_vld_q <= 1'b0;
    end else if (kw_fire) begin
      pf_vld_q <= 1'b0;
    end else if (arrive) begin
      pf_q     <= RAM_DATA;
      pf_vld_q <= 1'b1;
    end
  end
`else
  word_t kw_q;

  assign KW_VALID = (state_q == ST_OUT);
  assign KW       = kw_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      kw_q <= '0;
    end else if (state_q == ST_WAIT && arrive) begin
      kw_q <= RAM_DATA + w_t;
    end
  end
`endif

endmodule

// File: tb/tb_sha256_kw_sched.sv
// Randomized self-checking bench for sha256_kw_sched against a full 64-word schedule model.
module tb_sha256_kw_sched;

  localparam int ADDR_W = 7;
`ifdef KWSCHED_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              COPY_ROM_COMPLETE = 1'b0;
  logic              START = 1'b0;
  logic [31:0]       MSG_WORD = '0;
  logic              MSG_VALID = 1'b0;
  logic              KW_READY = 1'b0;
  logic              MSG_READY, RAM_RD, KW_VALID, BUSY, DONE;
  logic [ADDR_W-1:0] RAM_ADDR;
  logic [31:0]       RAM_DATA, KW;
  logic [5:0]        ROUND;

  always #5 CLK = ~CLK;

  sha256_kw_sched #(.K_BASE(8), .ADDR_W(ADDR_W), .RAM_LAT(1)) dut (
    .CLK(CLK), .RST(RST), .COPY_ROM_COMPLETE(COPY_ROM_COMPLETE), .START(START),
    .MSG_WORD(MSG_WORD), .MSG_VALID(MSG_VALID), .MSG_READY(MSG_READY),
    .RAM_ADDR(RAM_ADDR), .RAM_RD(RAM_RD), .RAM_DATA(RAM_DATA),
    .KW(KW), .KW_VALID(KW_VALID), .KW_READY(KW_READY), .ROUND(ROUND),
    .BUSY(BUSY), .DONE(DONE)
  );

  logic [31:0] k_tab [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  logic [31:0] h_tab [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  // RAM model with one cycle of read latency and a per-address read counter.
  logic [31:0] ram_img [128];
  logic [31:0] ram_q = '0;
  int          rd_cnt [128];
  assign RAM_DATA = ram_q;

  always @(posedge CLK) begin
    if (RAM_RD) begin
      ram_q            <= ram_img[RAM_ADDR];
      rd_cnt[RAM_ADDR] <= rd_cnt[RAM_ADDR] + 1;
    end
  end

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] msg [16];
  logic [31:0] exp_kw [64];
  logic [31:0] got_kw [64];
  logic [5:0]  got_rnd [64];
  int          rd_base [128];
  int          n_xfer, first_valid, first_cyc, last_cyc, done_cyc, busy_low, stall_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic model_block();
    logic [31:0] w [64];
    for (int i = 0; i < 64; i++) begin
      if (i < 16) w[i] = msg[i];
      else w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
      exp_kw[i] = k_tab[i] + w[i];
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) msg[i] = '0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, 32'({MSG_READY, RAM_RD, KW_VALID, BUSY, DONE}), 32'd0);
    check({tag, "_addr"}, 32'(RAM_ADDR), 32'd0);
    check({tag, "_kw"}, KW, 32'd0);
    check({tag, "_round"}, 32'(ROUND), 32'd0);
  endtask

  // gap_mode: 0 = back-to-back, 1 = every other cycle, 2 = random.
  task automatic feed_msg(input int gap_mode, input int n_words);
    int  i = 0;
    int  guard = 0;
    bit  v;
    while (i < n_words && guard < 400) begin
      @(negedge CLK);
      v = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? (guard % 2 == 1) : 1'($urandom_range(0, 1));
      MSG_VALID = v;
      MSG_WORD  = v ? msg[i] : $urandom();
      if (v && MSG_READY) i++;
      guard++;
    end
    @(negedge CLK);
    MSG_VALID = 1'b0;
    check("msg_words_taken", 32'(i), 32'(n_words));
    if (n_words == 16) check("msg_ready_drop", 32'(MSG_READY), 32'd0);
  endtask

  task automatic consume(input int stall_round, input int stall_len, input bit start_mid);
    int cyc = 0;
    bit done_seen = 1'b0;
    bit mid_sent = 1'b0;
    bit stall;
    n_xfer = 0; first_valid = -1; busy_low = 0; stall_done = 0; done_cyc = -1;
    while (!done_seen && cyc < 2000) begin
      @(negedge CLK);
      START = 1'b0;
      if (DONE) begin done_seen = 1'b1; done_cyc = cyc; end
      if (!BUSY && !DONE) busy_low++;
      if (KW_VALID && first_valid < 0) first_valid = cyc;
      stall = KW_VALID && (int'(ROUND) == stall_round) && (stall_done < stall_len);
      if (stall) begin
        stall_done++;
        check("stall_kw", KW, exp_kw[stall_round]);
        check("stall_round", 32'(ROUND), 32'(stall_round));
      end
      KW_READY = !stall;
      if (KW_VALID && !stall) begin
        if (n_xfer < 64) begin got_kw[n_xfer] = KW; got_rnd[n_xfer] = ROUND; end
        if (n_xfer == 0) first_cyc = cyc;
        last_cyc = cyc;
        n_xfer++;
      end
      if (start_mid && !mid_sent && KW_VALID && ROUND == 6'd30) begin
        START = 1'b1;
        mid_sent = 1'b1;
      end
      cyc++;
    end
    KW_READY = 1'b0;
    check("done_seen", 32'(done_seen), 32'd1);
    check("done_after_last", 32'(done_cyc - last_cyc), 32'd1);
    @(negedge CLK);
    check("idle_after_done", 32'({BUSY, DONE, KW_VALID}), 32'd0);
  endtask

  task automatic run_block(input int gap_mode, input int stall_round, input int stall_len,
                           input bit start_mid, input bit drop_crc);
    int bad = 0;
    int rnd_err = 0;
    model_block();
    for (int a = 0; a < 128; a++) rd_base[a] = rd_cnt[a];
    for (int i = 0; i < 64; i++) got_kw[i] = 'x;
    @(negedge CLK);
    START = 1'b1;
    COPY_ROM_COMPLETE = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    check("busy_on_start", 32'(BUSY), 32'd1);
    if (drop_crc) COPY_ROM_COMPLETE = 1'b0;
    feed_msg(gap_mode, 16);
    consume(stall_round, stall_len, start_mid);
    COPY_ROM_COMPLETE = 1'b1;
    check("n_xfer", 32'(n_xfer), 32'd64);
    check("busy_low_cycles", 32'(busy_low), 32'd0);
    check("first_kw_latency", 32'(first_valid), PF ? 32'd0 : 32'd1);
    check("kw_span", 32'(last_cyc - first_cyc), 32'((PF ? 63 : 189) + stall_done));
    for (int i = 0; i < 64; i++) begin
      check($sformatf("kw[%0d]", i), got_kw[i], exp_kw[i]);
      if (int'(got_rnd[i]) != i) rnd_err++;
    end
    check("round_order_errors", 32'(rnd_err), 32'd0);
    for (int a = 0; a < 128; a++)
      if (rd_cnt[a] - rd_base[a] != ((a >= 8 && a < 72) ? 1 : 0)) bad++;
    check("reads_once_8_to_71", 32'(bad), 32'd0);
  endtask

  initial begin
    int seen;
    for (int a = 0; a < 128; a++) begin
      ram_img[a] = (a < 8) ? h_tab[a] : (a < 72) ? k_tab[a-8] : 32'hdeadbeef;
      rd_cnt[a]  = 0;
    end

    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    RST = 1'b0;

    // START without the ROM copy must be ignored.
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge CLK);
      if (MSG_READY || BUSY || RAM_RD) seen++;
    end
    check("no_rom_ignored", 32'(seen), 32'd0);

    set_abc();
    run_block(0, -1, 0, 1'b0, 1'b0);
    check("abc_kw0", got_kw[0], 32'ha3ec9318);
    check("abc_kw1", got_kw[1], 32'h71374491);
    check("abc_kw15", got_kw[15], 32'hc19bf18c);
    check("abc_kw16", got_kw[16], 32'h45fdcd41);

    run_block(0, 16, 5, 1'b0, 1'b0);
    check("stall_cycles", 32'(stall_done), 32'd5);
    check("stall_rd_24", 32'(rd_cnt[24] - rd_base[24]), 32'd1);

    // Abort during LOAD after 7 words; outputs must clear within the same cycle.
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    feed_msg(0, 7);
    RST = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge CLK);
    RST = 1'b0;
    run_block(0, -1, 0, 1'b0, 1'b0);
    check("after_rst_kw0", got_kw[0], 32'ha3ec9318);

    run_block(1, -1, 0, 1'b1, 1'b0);

    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 16; i++) msg[i] = $urandom();
      run_block(2, int'($urandom_range(0, 63)), int'($urandom_range(0, 4)), 1'b0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
